fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read-side consumer for the team's synchronous FIFO. Whenever enabled and the FIFO is non-empty, the block pops one word through the FIFO's `read`/`empty`/`dout` port and serializes it as an asynchronous UART frame on `tx`: start bit, data LSB first, optional parity bit, stop bit. It sits between the FIFO's read port and the chip pad.

## Interface

**Parameters**
- `WIDTH`, default 8: data bits per frame. Must match the FIFO `WIDTH`.
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit. Legal range is 2 to 2^`CNT_WIDTH`−1.
- `CNT_WIDTH`, default 16: width of the baud counter.

**Ports**
- `clk`, input, 1 bit: clock. All logic is rising-edge.
- `rstn`, input, 1 bit: reset, asynchronous, active-low.
- `enable`, input, 1 bit: permits fetching a new word. It is sampled only in IDLE.
- `fifo_empty`, input, 1 bit: FIFO `empty` flag.
- `fifo_rd`, output, 1 bit: FIFO `read` strobe. Registered, one-cycle pulse.
- `fifo_dout`, input, `WIDTH` bits: FIFO `dout`. Valid from the edge after the edge that sampled `fifo_rd`.
- `tx`, output, 1 bit: serial line. Registered; idles high.
- `busy`, output, 1 bit: high whenever state ≠ IDLE.
- `frame_done`, output, 1 bit: one-cycle pulse when a stop bit completes.

## Operation

**Reset values (async, `rstn` = 0):** `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0, shift register 0.

**State machine:** IDLE → REQ → FETCH → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:** if `enable` && !`fifo_empty`, set `fifo_rd`<=1 and go to REQ. Otherwise stay, with `tx`=1.
- **REQ:** the FIFO samples `fifo_rd` at this cycle's closing edge. Set `fifo_rd`<=0 and go to FETCH.
- **FETCH:** shift register <= `fifo_dout`, `tx`<=0, baud counter <= 0, bit counter <= 0. Go to START.
- **START:** hold `tx`=0 for `CLKS_PER_BIT` cycles, then drive `tx`<=shreg[0] and go to DATA.
- **DATA:** each bit lasts `CLKS_PER_BIT` cycles. At the end of a bit, shift right and increment the bit counter. After bit `WIDTH`−1, go to PARITY if it is compiled in, otherwise go to STOP with `tx`<=1.
- **PARITY:** one bit time, then go to STOP with `tx`<=1.
- **STOP:** hold `tx`=1 for `CLKS_PER_BIT` cycles. On the final cycle, set `frame_done`<=1 for one cycle and go to IDLE.

**Counters:**
- The baud counter counts 0..`CLKS_PER_BIT`−1 and wraps to 0 at each bit boundary.
- The bit counter is width $clog2(`WIDTH`)+1 and must not overflow at `WIDTH`=2^n.

**Boundary conditions:**
- **`enable` drops mid-frame:** the current frame completes. No new read is issued.
- **`fifo_empty` rises after a read is issued:** cannot occur. This block is the only reader and empty is checked only in IDLE. No re-check is made in REQ or FETCH.
- **FIFO goes empty after the last word:** that word is still transmitted. The block then stays in IDLE with `tx`=1.
- **Reset mid-frame:** `tx` returns to 1 immediately and the partial frame is discarded. An already-popped word is lost; this is accepted.
- **`fifo_rd` constraint:** never asserted in two consecutive cycles, and never asserted outside IDLE→REQ.

## Timing

- **`fifo_rd` to start bit:** `fifo_rd` is high in cycle *k*. `tx` falls at the edge ending cycle *k*+1, i.e. 2 edges after the edge that raised `fifo_rd`.
- **Frame length:** (2 + `WIDTH` [+1 with parity]) × `CLKS_PER_BIT` cycles. Defaults give 160 cycles, or 176 with parity.
- **Back-to-back frames:** the gap between stop-bit end and the next start bit is exactly 3 idle-high cycles (IDLE, REQ, FETCH).
- **`frame_done`:** asserted in the cycle after the last stop-bit cycle, coincident with IDLE.
- **`busy`:** decoded from the state register. It rises with REQ and falls with the return to IDLE.

## Configuration

- **`FIFO_UART_TX_PARITY_EN` defined:** the PARITY state exists and transmits the even-parity bit, i.e. the XOR of all `WIDTH` data bits, computed from the word captured in FETCH.
- **Undefined:** there is no PARITY state, and DATA goes directly to STOP.

## Test plan

1. **Reset:** with `rstn` low, and after release with FIFO empty and `enable`=1 for 100 cycles, expect `tx`=1, `fifo_rd`=0 and `busy`=0 throughout.
2. **Single word:** `CLKS_PER_BIT`=4, FIFO holds 8'hA5, `enable`=1.
   - Expect exactly one `fifo_rd` pulse.
   - Expect `tx` low 2 edges later for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles.
   - Expect `frame_done` after 40 cycles; with parity, bit 0 is inserted after the data and `frame_done` comes after 44 cycles.
3. **Back-to-back:** FIFO holds 8'h00, 8'hFF, 8'h3C. Expect three frames in order, exactly 3 high cycles between stop end and the next start, and 3 `fifo_rd` pulses total.
4. **`enable` drop:** deassert `enable` during the DATA bits of frame 1 with 2 words queued. Expect frame 1 to complete, no further `fifo_rd`, and `tx`=1. On re-enable, expect the second word to transmit.
5. **Reset mid-frame:** assert `rstn` low during DATA bit 3. Expect `tx`=1 and `busy`=0 immediately. After release, the next queued word transmits normally.
6. **Parity, `WIDTH`=8, `FIFO_UART_TX_PARITY_EN` defined:** 8'h07 gives parity bit 1, and 8'h03 gives parity bit 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Read-side consumer for the synchronous FIFO. When enabled and the FIFO is
// non-empty it pops one word and sends it as a UART frame on tx:
// start bit, WIDTH data bits LSB first, optional even-parity bit, stop bit.
//
// Build option: define FIFO_UART_TX_PARITY_EN to add the even-parity bit
// (XOR of all data bits) between the last data bit and the stop bit.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   enable      permits fetching a new word (sampled only in IDLE)
//   fifo_empty  FIFO empty flag
//   fifo_rd     FIFO read strobe, registered single-cycle pulse
//   fifo_dout   FIFO read data, valid the edge after fifo_rd is sampled
//   tx          serial line, registered, idles high
//   busy        high whenever the FSM is not in IDLE
//   frame_done  one-cycle pulse after the stop bit completes
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  // state  | meaning
  // IDLE   | line high, waiting for enable && !fifo_empty
  // REQ    | fifo_rd high, FIFO pops at the closing edge
  // FETCH  | capture fifo_dout, drop line for the start bit
  // START  | start bit
  // DATA   | data bits, LSB first
  // PARITY | even-parity bit (parity builds only)
  // STOP   | stop bit, frame_done raised on its last cycle

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd6;
`endif

  // One extra bit so the counter can reach WIDTH when WIDTH is a power of two.
  localparam int BIT_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(WIDTH - 1);

  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] baud_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     shreg_next;
  logic                 baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign shreg_next = shreg >> 1;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            fifo_rd <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          shreg    <= fifo_dout;
          tx       <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= ^fifo_dout;
`endif
          state    <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= shreg_next;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              tx <= shreg_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud_cnt   <= '0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO read-port model feeding the DUT, a
// scoreboard of expected words, and a UART line monitor that decodes frames
// and compares them against the scoreboard.
module tb_fifo_uart_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 2 + W + P;

  logic         clk;
  logic         rstn;
  logic         enable;
  logic         fifo_empty;
  logic         fifo_rd;
  logic [W-1:0] fifo_dout;
  logic         tx;
  logic         busy;
  logic         frame_done;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO model and scoreboard
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int rd_pulses   = 0;
  int rd_consec   = 0;
  int underflow   = 0;
  logic prev_rd   = 1'b0;

  initial begin
    fifo_dout = '0;
    forever begin
      @(posedge clk);
      if (rstn && fifo_rd) begin
        rd_pulses++;
        if (prev_rd) rd_consec++;
        if (fifo_q.size() == 0) underflow++;
        else fifo_dout <= fifo_q.pop_front();
      end
      prev_rd = rstn && fifo_rd;
    end
  end

  initial begin
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Line monitor
  int   cyc = 0;
  int   last_rd_cyc = -100;
  int   start_cyc = 0;
  int   end_cyc = 0;
  bit   have_end = 0;
  bit   in_frame = 0;
  bit   done_pending = 0;
  bit   stable = 1;
  int   samp = 0;
  int   frames = 0;
  int   aborted = 0;
  int   spurious_done = 0;
  logic [15:0] bits;
  int   gap_q[$];

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    int b;
    bits = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_rd) last_rd_cyc = cyc;
      if (done_pending) begin
        chk("frame_done_timing", {31'b0, frame_done}, 32'd1);
        done_pending = 0;
      end else if (frame_done) begin
        spurious_done++;
      end
      if (!rstn) begin
        if (in_frame) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_frame = 0;
          aborted++;
        end
        have_end = 0;
      end else begin
        if (!in_frame && tx == 1'b0) begin
          in_frame  = 1;
          samp      = 0;
          stable    = 1;
          start_cyc = cyc;
          chk("rd_to_start_latency", cyc - last_rd_cyc, 32'd2);
          if (have_end) gap_q.push_back(cyc - end_cyc - 1);
        end
        if (in_frame) begin
          b = samp / C;
          if (samp % C == 0) bits[b] = tx;
          else if (tx != bits[b]) stable = 0;
          samp++;
          if (samp == NB * C) begin
            in_frame     = 0;
            end_cyc      = cyc;
            have_end     = 1;
            done_pending = 1;
            frames++;
            for (int i = 0; i < W; i++) got[i] = bits[i + 1];
            chk("bit_stable", {31'b0, stable}, 32'd1);
            chk("stop_bit", {31'b0, bits[NB - 1]}, 32'd1);
            if (exp_q.size() == 0) begin
              chk("frame_expected", 32'd0, 32'd1);
            end else begin
              want = exp_q.pop_front();
              chk("data_word", got, want);
`ifdef FIFO_UART_TX_PARITY_EN
              chk("parity_bit", {31'b0, bits[W + 1]}, {31'b0, ^want});
`endif
            end
          end
        end
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (frames < n) chk("frame_wait_timeout", frames, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bit(input int s, input int budget);
    int k;
    k = 0;
    while (!(in_frame && samp > s) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(in_frame && samp > s)) chk("bit_wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, f0, ab0, viol;
    rstn   = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_frame_done", {31'b0, frame_done}, 32'd0);

    // Empty FIFO, enabled: nothing may happen.
    enable = 1'b1;
    rstn   = 1'b1;
    viol   = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("idle_empty_quiet", viol, 32'd0);

    // Single word
    rd0 = rd_pulses; f0 = frames;
    push(8'hA5);
    wait_frames(f0 + 1, 300);
    repeat (10) @(negedge clk);
    chk("single_rd_pulses", rd_pulses - rd0, 32'd1);
    chk("single_idle_tx", {31'b0, tx}, 32'd1);
    chk("single_idle_busy", {31'b0, busy}, 32'd0);

    // Back-to-back
    gap_q.delete();
    rd0 = rd_pulses; f0 = frames;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_frames(f0 + 3, 800);
    repeat (10) @(negedge clk);
    chk("b2b_rd_pulses", rd_pulses - rd0, 32'd3);
    chk("b2b_gap_count", gap_q.size(), 32'd3);
    if (gap_q.size() == 3) begin
      chk("b2b_gap_1", gap_q[1], 32'd3);
      chk("b2b_gap_2", gap_q[2], 32'd3);
    end

    // Enable drop mid-frame
    rd0 = rd_pulses; f0 = frames;
    push(8'h11); push(8'h22);
    wait_bit(2 * C, 300);
    enable = 1'b0;
    wait_frames(f0 + 1, 300);
    repeat (50) @(negedge clk);
    chk("endrop_rd_pulses", rd_pulses - rd0, 32'd1);
    chk("endrop_frames", frames - f0, 32'd1);
    chk("endrop_tx_high", {31'b0, tx}, 32'd1);
    chk("endrop_busy", {31'b0, busy}, 32'd0);
    enable = 1'b1;
    wait_frames(f0 + 2, 300);
    chk("reenable_rd_pulses", rd_pulses - rd0, 32'd2);

    // Reset during data bit 3
    f0 = frames; ab0 = aborted;
    push(8'h5A); push(8'hC3);
    wait_bit(4 * C, 300);
    rstn = 1'b0;
    #1;
    chk("midreset_tx", {31'b0, tx}, 32'd1);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_fifo_rd", {31'b0, fifo_rd}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_frames(f0 + 1, 300);
    chk("midreset_aborted", aborted - ab0, 32'd1);
    chk("midreset_frames", frames - f0, 32'd1);

    // Parity patterns (plain frames when parity is not built in)
    f0 = frames;
    push(8'h07); push(8'h03);
    wait_frames(f0 + 2, 600);
    repeat (10) @(negedge clk);

    chk("no_spurious_frame_done", spurious_done, 32'd0);
    chk("no_consecutive_rd", rd_consec, 32'd0);
    chk("no_fifo_underflow", underflow, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
